// File: rtl/efpga_cfg_pkg.sv
// Shared types and constants for the eFPGA configuration-chain loader.
package efpga_cfg_pkg;

  localparam int unsigned CCFF_WORD_W = 32;

  localparam logic [31:0] CCFF_CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CCFF_CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESET,
    ST_SHIFT,
    ST_DONE
  } ccff_state_e;

endpackage

// File: rtl/efpga_ccff_crc32.sv
// Serial MSB-first CRC-32 over the configuration bit stream; clr reloads the init value.
module efpga_ccff_crc32
  import efpga_cfg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [31:0] crc_o,
  output logic [31:0] crc_next_o
);

  always_comb begin
    crc_next_o = crc_o;
    if (en_i) begin
      crc_next_o = {crc_o[30:0], 1'b0} ^ ((crc_o[31] ^ bit_i) ? CCFF_CRC_POLY : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_o <= '0;
    end else if (clr_i) begin
      crc_o <= CCFF_CRC_INIT;
    end else begin
      crc_o <= crc_next_o;
    end
  end

endmodule

// File: rtl/efpga_ccff_loader.sv
// Streams 32-bit bitstream words MSB-first onto the eFPGA configuration chain.
// Optional CRC-32 check of the shifted stream when EFPGA_CCFF_CRC_EN is defined.
module efpga_ccff_loader
  import efpga_cfg_pkg::*;
#(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [CNT_W-1:0]       chain_len_i,
  input  logic [CCFF_WORD_W-1:0] wdata_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  output logic                   ccff_head_o,
  output logic                   ccff_shift_o,
  input  logic                   ccff_tail_i,
  output logic                   prog_reset_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
`ifdef EFPGA_CCFF_CRC_EN
  input  logic [31:0]            crc_exp_i,
  output logic [31:0]            crc_o,
`endif
  output logic [CNT_W-1:0]       bits_left_o
);

  localparam int unsigned      RC_W      = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]  RC_LOAD   = RC_W'(RST_CYCLES);
  localparam logic [5:0]       WORD_BITS = 6'(CCFF_WORD_W);

  ccff_state_e            state, state_d;
  logic [RC_W-1:0]        rst_cnt;
  logic [CNT_W-1:0]       bits_left;
  logic [CCFF_WORD_W-1:0] hold, sreg;
  logic                   hold_vld;
  logic [5:0]             sreg_cnt;
  logic                   head_q, shift_q, preset_q, busy_q, done_q, err_q;

  logic start_ok, abort_ok, do_shift, last_bit, refill, accept, flush, done_set, crc_bad;
  logic unused_tail;

  assign unused_tail = ccff_tail_i;

  assign start_ok = start_i && !abort_i && (state inside {ST_IDLE, ST_DONE});
  assign abort_ok = abort_i && (state inside {ST_RESET, ST_SHIFT});
  assign do_shift = (state == ST_SHIFT) && !abort_i && (sreg_cnt != '0) && (bits_left != '0);
  assign last_bit = do_shift && (bits_left == CNT_W'(1));
  // Refill on the last sreg bit keeps a continuous stream at one bit per cycle.
  assign refill   = (state == ST_SHIFT) && !abort_i && hold_vld &&
                    ((sreg_cnt == '0) || (do_shift && sreg_cnt == 6'd1));
  assign wready_o = !hold_vld &&
                    ((state == ST_SHIFT) || (state == ST_RESET && bits_left != '0));
  assign accept   = wvalid_i && wready_o;

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start_ok) state_d = ST_RESET;
      ST_RESET: begin
        if (abort_i)                        state_d = ST_IDLE;
        else if (rst_cnt == RC_W'(1))       state_d = (bits_left == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort_i)       state_d = ST_IDLE;
        else if (last_bit) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flush    = !(state_d inside {ST_RESET, ST_SHIFT});
  assign done_set = (state_d == ST_DONE) && (state != ST_DONE);

`ifdef EFPGA_CCFF_CRC_EN
  logic [31:0] crc_exp_q, crc_next;

  efpga_ccff_crc32 u_crc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (start_ok),
    .en_i       (do_shift),
    .bit_i      (sreg[CCFF_WORD_W-1]),
    .crc_o      (crc_o),
    .crc_next_o (crc_next)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       crc_exp_q <= '0;
    else if (start_ok) crc_exp_q <= crc_exp_i;
  end

  // Compare against the value that includes the bit shifted on the DONE-entry edge.
  assign crc_bad = (crc_next != crc_exp_q);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      rst_cnt   <= '0;
      bits_left <= '0;
      hold      <= '0;
      hold_vld  <= 1'b0;
      sreg      <= '0;
      sreg_cnt  <= '0;
      head_q    <= 1'b0;
      shift_q   <= 1'b0;
      preset_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state    <= state_d;
      preset_q <= (state_d == ST_RESET);
      busy_q   <= (state_d inside {ST_RESET, ST_SHIFT});
      shift_q  <= do_shift;

      if (start_ok)                                     rst_cnt <= RC_LOAD;
      else if (state == ST_RESET && rst_cnt > RC_W'(1)) rst_cnt <= rst_cnt - RC_W'(1);

      if (start_ok)      bits_left <= chain_len_i;
      else if (do_shift) bits_left <= bits_left - CNT_W'(1);

      if (start_ok)      done_q <= 1'b0;
      else if (done_set) done_q <= 1'b1;

      if (start_ok)                  err_q <= 1'b0;
      else if (abort_ok)             err_q <= 1'b1;
      else if (done_set && crc_bad)  err_q <= 1'b1;

      if (accept) hold <= wdata_i;

      if (flush)       hold_vld <= 1'b0;
      else if (accept) hold_vld <= 1'b1;
      else if (refill) hold_vld <= 1'b0;

      if (do_shift) head_q <= sreg[CCFF_WORD_W-1];

      if (flush) begin
        sreg_cnt <= '0;
      end else if (refill) begin
        sreg     <= hold;
        sreg_cnt <= WORD_BITS;
      end else if (do_shift) begin
        sreg     <= {sreg[CCFF_WORD_W-2:0], 1'b0};
        sreg_cnt <= sreg_cnt - 6'd1;
      end
    end
  end

  assign ccff_head_o  = head_q;
  assign ccff_shift_o = shift_q;
  assign prog_reset_o = preset_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign bits_left_o  = bits_left;

endmodule
